// File: rtl/aes_stream_driver.sv
// aes_stream_driver: valid/ready host wrapper around a fixed-latency aes_128 core
//   in_valid/in_ready/in_pt/in_key : plaintext+key intake, credit limited
//   core_state/core_key/core_out   : registered core inputs, core result input
//   out_valid/out_ready/out_ct     : result FIFO head
//   busy                           : blocks in flight or buffered
//   AES_DRV_TAG_EN adds in_tag/out_tag carried alongside each block
module aes_stream_driver #(
  parameter int LATENCY = 20,
  parameter int FIFO_DEPTH = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_pt,
  input  logic [127:0]     in_key,
`ifdef AES_DRV_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag,
`endif
  output logic [127:0]     core_state,
  output logic [127:0]     core_key,
  input  logic [127:0]     core_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_ct,
  output logic             busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  if (LATENCY < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TAG_W < 1) begin : g_bad
    $error("aes_stream_driver: illegal parameters");
  end
  logic [127:0] state_q, key_q;
  logic [LATENCY-1:0] vld_q;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] infl_q, infl_d, cnt_q, cnt_d, occ;
  logic [127:0] ct_mem [FIFO_DEPTH];
  logic issue, push, pop, full, empty;
  assign core_state = state_q;
  assign core_key = key_q;
  assign out_valid = cnt_q != '0;
  assign busy = occ != '0;
  assign out_ct = out_valid ? ct_mem[rd_q[AW-1:0]] : '0;
  always_comb begin
    occ = infl_q + cnt_q;
    in_ready = !rst && occ < CW'(FIFO_DEPTH);
    issue = in_valid && in_ready;
    push = vld_q[LATENCY-1];
    pop = out_valid && out_ready;
    infl_d = infl_q + CW'(issue) - CW'(push);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    wr_d = wr_q + (AW+1)'(push);
    rd_d = rd_q + (AW+1)'(pop);
    full = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
    empty = wr_q == rd_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      key_q <= '0;
      vld_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      infl_q <= '0;
      cnt_q <= '0;
    end else begin
      if (issue) begin
        state_q <= in_pt;
        key_q <= in_key;
      end
      vld_q <= {vld_q[LATENCY-2:0], issue};
      wr_q <= wr_d;
      rd_q <= rd_d;
      infl_q <= infl_d;
      cnt_q <= cnt_d;
    end
  end
  // storage is not reset; the cleared pointers make stale entries unreachable
  always_ff @(posedge clk) if (push) ct_mem[wr_q[AW-1:0]] <= core_out;
`ifdef AES_DRV_TAG_EN
  logic [TAG_W-1:0] tag_q [LATENCY];
  logic [TAG_W-1:0] tag_mem [FIFO_DEPTH];
  assign out_tag = out_valid ? tag_mem[rd_q[AW-1:0]] : '0;
  // tag pipe runs unqualified; only entries tracked by vld_q ever reach the FIFO
  always_ff @(posedge clk) begin
    tag_q[0] <= in_tag;
    for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
    if (push) tag_mem[wr_q[AW-1:0]] <= tag_q[LATENCY-1];
  end
`endif
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
endmodule

// File: tb/tb_aes_stream_driver.sv
// tb_aes_stream_driver: random-stimulus bench with AES core model and transaction-level scoreboard
module tb_aes_stream_driver;
  localparam int LAT = 20;
  localparam int DEPTH = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [127:0] in_pt = '0;
  logic [127:0] in_key = '0;
  logic in_ready, out_valid, busy;
  logic [127:0] core_state, core_key, core_out, out_ct;
`ifdef AES_DRV_TAG_EN
  logic [7:0] in_tag = '0;
  logic [7:0] out_tag;
`endif
  always #5 clk = ~clk;
  aes_stream_driver #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pt(in_pt),
    .in_key(in_key),
`ifdef AES_DRV_TAG_EN
    .in_tag(in_tag),
    .out_tag(out_tag),
`endif
    .core_state(core_state),
    .core_key(core_key),
    .core_out(core_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ct(out_ct),
    .busy(busy)
  );
  logic [7:0] sb [256];
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [127:0] aes(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] k [176];
    logic [7:0] w [4];
    logic [7:0] rc, x0;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) w[j] = k[i-4+j];
      if (i % 16 == 0) begin
        x0 = w[0];
        w[0] = sb[w[1]] ^ rc;
        w[1] = sb[w[2]];
        w[2] = sb[w[3]];
        w[3] = sb[x0];
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) k[i+j] = k[i-16+j] ^ w[j];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end else begin
          for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= k[16*r+i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction
  // free-running core: result of the inputs held after edge E appears after edge E+LAT-1
  logic [127:0] cp [LAT-1];
  always @(posedge clk) begin
    cp[0] <= aes(core_state, core_key);
    for (int i = 1; i < LAT - 1; i++) cp[i] <= cp[i-1];
  end
  assign core_out = cp[LAT-2];
  logic [127:0] ct_q [$];
  int rdy_q [$];
  logic [7:0] tg_q [$];
  int n = 0;
  int checks = 0;
  int failures = 0;
  int acc = 0;
  int pops = 0;
  logic hs = 1'b0;
  logic [7:0] tag_nxt = '0;
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic chk(input string t, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", t, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic v, input logic o, input logic [127:0] pt, input logic [127:0] key);
    logic ev;
    @(negedge clk);
    rst = r;
    in_valid = v;
    out_ready = o;
    in_pt = pt;
    in_key = key;
`ifdef AES_DRV_TAG_EN
    in_tag = tag_nxt;
`endif
    #1;
    ev = ct_q.size() > 0 && rdy_q[0] <= n;
    chk("in_ready", in_ready, !r && ct_q.size() < DEPTH);
    chk("busy", busy, ct_q.size() != 0);
    chk("out_valid", out_valid, ev);
    if (ev) chk("out_ct", out_ct, ct_q[0]);
`ifdef AES_DRV_TAG_EN
    if (ev) chk("out_tag", out_tag, tg_q[0]);
`endif
    hs = v && in_ready;
    if (r) begin
      ct_q.delete();
      rdy_q.delete();
      tg_q.delete();
    end else begin
      if (ev && o) begin
        void'(ct_q.pop_front());
        void'(rdy_q.pop_front());
        void'(tg_q.pop_front());
        pops++;
      end
      if (hs) begin
        ct_q.push_back(aes(pt, key));
        rdy_q.push_back(n + LAT + 1);
        tg_q.push_back(tag_nxt);
        acc++;
      end
    end
    n++;
  endtask
  task automatic drain(input int k);
    repeat (k) cyc(1'b0, 1'b0, 1'b1, '0, '0);
  endtask
  initial begin
    logic [7:0] p, b;
    logic found, seen;
    logic [127:0] ctf;
    int hs_n, lat, a0, p0, i, guard;
    for (int x = 0; x < 256; x++) begin
      p = 8'h01;
      for (int e = 0; e < 254; e++) p = gmul(p, 8'(x));
      b = p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
      sb[x] = b;
    end
    repeat (2) @(posedge clk);
    cyc(1'b1, 1'b1, 1'b1, '0, '0);
    chk("rst_state", core_state, '0);
    chk("rst_key", core_key, '0);
    chk("rst_ct", out_ct, '0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    hs_n = n;
    cyc(1'b0, 1'b1, 1'b1, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
    chk("fips_hs", hs, 1'b1);
    found = 1'b0;
    lat = -1;
    ctf = '0;
    for (int k = 0; k < 40 && !found; k++) begin
      drain(1);
      if (out_valid) begin
        found = 1'b1;
        lat = n - 2 - hs_n;
        ctf = out_ct;
      end
    end
    chk("fips_seen", found, 1'b1);
    chk("fips_lat", lat, 20);
    chk("fips_ct", ctf, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    drain(1);
    chk("fips_busy", busy, 1'b0);
    a0 = acc;
    p0 = pops;
    repeat (64) cyc(1'b0, 1'b1, 1'b1, rnd128(), rnd128());
    chk("b2b_acc", acc - a0, 64);
    drain(30);
    chk("b2b_pops", pops - p0, 64);
    a0 = acc;
    repeat (40) cyc(1'b0, 1'b1, 1'b0, rnd128(), rnd128());
    chk("fill_acc", acc - a0, 32);
    chk("fill_ready", in_ready, 1'b0);
    drain(40);
    chk("fill_busy", busy, 1'b0);
    a0 = acc;
    p0 = pops;
    guard = 0;
    while (acc - a0 < 2000 && guard < 30000) begin
      cyc(1'b0, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 30, rnd128(), rnd128());
      guard++;
    end
    chk("rand_acc", acc - a0, 2000);
    drain(80);
    chk("rand_pops", pops - p0, 2000);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, rnd128(), rnd128());
    repeat (17) cyc(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (5) cyc(1'b0, 1'b1, 1'b0, rnd128(), rnd128());
    cyc(1'b0, 1'b0, 1'b0, '0, '0);
    chk("pre_rst_valid", out_valid, 1'b1);
    chk("pre_rst_busy", busy, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, '0, '0);
    drain(1);
    chk("post_rst_valid", out_valid, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      drain(1);
      seen |= out_valid;
    end
    chk("post_rst_quiet", seen, 1'b0);
`ifdef AES_DRV_TAG_EN
    i = 0;
    guard = 0;
    p0 = pops;
    while (i < 64 && guard < 2000) begin
      tag_nxt = 8'(i);
      cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), rnd128(), rnd128());
      if (hs) i++;
      guard++;
    end
    chk("tag_acc", i, 64);
    drain(60);
    chk("tag_pops", pops - p0, 64);
`else
    i = 0;
    chk("idle_ready", in_ready, 1'b1 + 1'(i));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
